// File: rtl/mig_eval_sequencer_if.sv
// Bus bundle for the MIG sequencer: program port, run control and result/status.
// The master side programs nodes and starts runs; the slave side is the sequencer.
interface mig_eval_sequencer_if #(
  parameter int NUM_PI    = 4,
  parameter int MAX_NODES = 16,
  parameter int SEL_W     = 5
);
  localparam int AW = $clog2(MAX_NODES);
  localparam int NW = $clog2(MAX_NODES + 1);
  localparam int PW = 3 * (SEL_W + 1);

  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [PW-1:0]     prog_data;
  logic [NW-1:0]     num_nodes;
  logic              start;
  logic [NUM_PI-1:0] pi;
  logic [SEL_W:0]    po_sel;
  logic              busy;
  logic              done;
  logic              po;
  logic              err;

  modport master (
    output prog_we, prog_addr, prog_data, num_nodes, start, pi, po_sel,
    input  busy, done, po, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, num_nodes, start, pi, po_sel,
    output busy, done, po, err
  );
endinterface

// File: rtl/mig_eval_sequencer.sv
// Sequential MIG evaluator: one shared MAJ3 with per-operand inversion walks a
// programmed node list, one node per clock, and registers the selected node as po.
module mig_eval_sequencer #(
  parameter int NUM_PI    = 4,
  parameter int MAX_NODES = 16,
  parameter int SEL_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  mig_eval_sequencer_if.slave   bus
);
  localparam int AW  = $clog2(MAX_NODES);
  localparam int NW  = $clog2(MAX_NODES + 1);
  localparam int PW  = 3 * (SEL_W + 1);
  localparam int PIW = (NUM_PI > 1) ? $clog2(NUM_PI) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state;
  logic [PW-1:0]        mem [MAX_NODES];
  logic [NUM_PI-1:0]    pi_q;
  logic [NW-1:0]        n_q;
  logic [SEL_W:0]       po_sel_q;
  logic [NW-1:0]        cnt;
  logic [MAX_NODES-1:0] val;
  logic [MAX_NODES-1:0] val_nxt;
  logic                 po_q;
  logic                 err_q;

  // Returns {fault, value}; a faulting source reads as 0 before inversion.
  // Node references are legal only below 'limit' (the current node or node count).
  function automatic logic [1:0] read_src(input logic [SEL_W-1:0]     sel,
                                          input logic [NUM_PI-1:0]    piv,
                                          input logic [MAX_NODES-1:0] vals,
                                          input logic [NW-1:0]        limit);
    logic [1:0] r;
    r = 2'b00;
    if (sel == '0)
      r = 2'b00;
    else if (int'(sel) <= NUM_PI)
      r = {1'b0, piv[PIW'(sel - SEL_W'(1))]};
    else if (int'(sel) > NUM_PI + MAX_NODES)
      r = 2'b10;
    else if (int'(sel) - NUM_PI - 1 >= int'(limit))
      r = 2'b10;
    else
      r = {1'b0, vals[AW'(sel - SEL_W'(NUM_PI + 1))]};
    return r;
  endfunction

  logic [PW-1:0] instr;
  logic [1:0]    ra, rb, rc, rp;
  logic          opa, opb, opc, maj;
  logic          last, fault_node, clamp;
  logic [NW-1:0] n_in;

  assign instr = mem[cnt[AW-1:0]];
  assign ra    = read_src(instr[0 +: SEL_W],               pi_q, val, cnt);
  assign rb    = read_src(instr[(SEL_W+1) +: SEL_W],       pi_q, val, cnt);
  assign rc    = read_src(instr[2*(SEL_W+1) +: SEL_W],     pi_q, val, cnt);
  assign opa   = ra[0] ^ instr[SEL_W];
  assign opb   = rb[0] ^ instr[2*SEL_W+1];
  assign opc   = rc[0] ^ instr[3*SEL_W+2];
  assign maj   = (opa & opb) | (opa & opc) | (opb & opc);

  // An empty program still spends one EVAL cycle, writing nothing.
  assign last       = (n_q == '0) || (cnt == n_q - NW'(1));
  assign fault_node = (n_q != '0) && (ra[1] | rb[1] | rc[1]);

  always_comb begin
    val_nxt = val;
    if (n_q != '0) val_nxt[cnt[AW-1:0]] = maj;
  end

  // po is resolved against the node values including the one written this cycle.
  assign rp    = read_src(po_sel_q[SEL_W-1:0], pi_q, val_nxt, n_q);
  assign clamp = (bus.num_nodes > NW'(MAX_NODES));
  assign n_in  = clamp ? NW'(MAX_NODES) : bus.num_nodes;

  always_ff @(posedge clk) begin
    if (bus.prog_we && state == ST_IDLE) mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pi_q     <= '0;
      n_q      <= '0;
      po_sel_q <= '0;
      cnt      <= '0;
      val      <= '0;
      po_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            pi_q     <= bus.pi;
            n_q      <= n_in;
            po_sel_q <= bus.po_sel;
            cnt      <= '0;
            val      <= '0;
            err_q    <= clamp;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          val <= val_nxt;
          if (last) begin
            err_q <= err_q | fault_node | rp[1];
            po_q  <= rp[0] ^ po_sel_q[SEL_W];
            state <= ST_DONE;
          end else begin
            err_q <= err_q | fault_node;
            cnt   <= cnt + NW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);
  assign bus.po   = po_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_mig_eval_sequencer.sv
// Directed bench for mig_eval_sequencer: a five-node program whose output is
// true only for pi=4'b1100, plus fault, empty-program, clamp and reset cases.
module tb_mig_eval_sequencer;
  localparam int NUM_PI    = 4;
  localparam int MAX_NODES = 16;
  localparam int SEL_W     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mig_eval_sequencer_if #(.NUM_PI(NUM_PI), .MAX_NODES(MAX_NODES), .SEL_W(SEL_W)) bus ();

  mig_eval_sequencer #(.NUM_PI(NUM_PI), .MAX_NODES(MAX_NODES), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [5:0] op(input bit inv, input int sel);
    return {inv, 5'(sel)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic writeNode(input int addr, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    @(posedge clk); #1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = {c, b, a};
    @(posedge clk); #1;
    bus.prog_we   = 1'b0;
  endtask

  // Start one run and follow it to done; optionally pokes start/prog_we mid-run.
  task automatic applyStimulus(input string tag, input logic [3:0] p, input int n,
                               input logic [5:0] ps, input int exp_cycles,
                               input logic exp_po, input logic exp_err, input bit disturb);
    int   cycles;
    int   dones;
    logic po_s;
    logic err_s;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.pi        = p;
    bus.num_nodes = 5'(n);
    bus.po_sel    = ps;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    cycles = -1;
    dones  = 0;
    po_s   = 1'b0;
    err_s  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        if (cycles < 0) begin
          cycles = c;
          po_s   = bus.po;
          err_s  = bus.err;
        end
      end
      if (disturb && c == 1) begin
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd4;
        bus.prog_data = '0;
      end
      if (disturb && c == 2) begin
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
      end
      if (cycles >= 0 && c >= cycles + 2) break;
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    checkOutput({tag, " done_cycle"}, 32'(cycles), 32'(exp_cycles));
    checkOutput({tag, " done_count"}, 32'(dones), 32'd1);
    checkOutput({tag, " po"}, 32'(po_s), 32'(exp_po));
    checkOutput({tag, " err"}, 32'(err_s), 32'(exp_err));
    checkOutput({tag, " po_hold"}, 32'(bus.po), 32'(exp_po));
    checkOutput({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dones;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.num_nodes = '0;
    bus.start     = 1'b0;
    bus.pi        = '0;
    bus.po_sel    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset po",   32'(bus.po),   32'd0);
    checkOutput("reset err",  32'(bus.err),  32'd0);
    rst = 1'b0;

    // sel 1..4 = pi0..pi3, node k = sel 5+k; n4 = pi2 & pi3 & ~pi0 & ~pi1
    writeNode(0, op(0, 3), op(0, 4), op(0, 0));
    writeNode(1, op(0, 4), op(1, 1), op(0, 0));
    writeNode(2, op(0, 5), op(0, 6), op(0, 0));
    writeNode(3, op(1, 1), op(1, 2), op(0, 0));
    writeNode(4, op(0, 7), op(0, 8), op(0, 0));
    for (int k = 5; k < MAX_NODES; k++) writeNode(k, op(0, 0), op(0, 0), op(0, 0));

    applyStimulus("basic", 4'b1100, 5, op(0, 9), 5, 1'b1, 1'b0, 1'b0);

    for (int p = 0; p < 16; p++)
      applyStimulus($sformatf("sweep pi=%0d", p), 4'(p), 5, op(0, 9), 5, (p == 12), 1'b0, 1'b0);
    for (int p = 0; p < 16; p++)
      applyStimulus($sformatf("inv pi=%0d", p), 4'(p), 5, op(1, 9), 5, (p != 12), 1'b0, 1'b0);

    applyStimulus("empty const1", 4'b0000, 0, op(1, 0), 1, 1'b1, 1'b0, 1'b0);
    applyStimulus("empty pi1",    4'b0010, 0, op(0, 2), 1, 1'b1, 1'b0, 1'b0);

    applyStimulus("busy start",   4'b1100, 5, op(0, 9), 5, 1'b1, 1'b0, 1'b1);
    applyStimulus("prog ignored", 4'b1100, 5, op(0, 9), 5, 1'b1, 1'b0, 1'b0);

    writeNode(1, op(0, 6), op(1, 1), op(0, 0));
    applyStimulus("self ref", 4'b1100, 5, op(0, 9), 5, 1'b0, 1'b1, 1'b0);
    writeNode(1, op(0, 4), op(1, 1), op(0, 0));
    applyStimulus("err cleared", 4'b1100, 5, op(0, 9), 5, 1'b1, 1'b0, 1'b0);

    applyStimulus("clamp",        4'b1100, 17, op(0, 9), 16, 1'b1, 1'b1, 1'b0);
    applyStimulus("po beyond",    4'b1100, 3,  op(0, 9), 3,  1'b0, 1'b1, 1'b0);
    applyStimulus("po beyond inv",4'b1100, 3,  op(1, 9), 3,  1'b1, 1'b1, 1'b0);
    applyStimulus("pre reset",    4'b1100, 5,  op(0, 9), 5,  1'b1, 1'b0, 1'b0);

    // Reset lands during node evaluation, after edge E+3
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.pi        = 4'b1100;
    bus.num_nodes = 5'd5;
    bus.po_sel    = op(0, 9);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst done", 32'(bus.done), 32'd0);
    checkOutput("midrst po",   32'(bus.po),   32'd0);
    checkOutput("midrst err",  32'(bus.err),  32'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    checkOutput("midrst no_done", 32'(dones), 32'd0);
    checkOutput("midrst po_after", 32'(bus.po), 32'd0);

    applyStimulus("after reset", 4'b1100, 5, op(0, 9), 5, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
